modport_slave: RTL and testbench
================================

# modport_slave

Avalon-MM slave register block sitting on the DUT side of the testbench Avalon-MM interface. It holds a small bank of read/write registers, a read-only ID register and a read-only transfer counter. Each access is stretched by a programmable number of wait states via `av_wait_req`.

## Interface
Parameters:
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.
- `NUM_REGS`, 16: number of R/W registers, mapped at addresses 0..NUM_REGS-1. Range 1..256.
- `WAIT_CYC`, 1: wait-state cycles per access. Range 0..15.
- `ID_ADDR`, 16'hFFF0: address of the read-only ID register.
- `ID_VAL`, 16'hA5C3: ID register value, truncated or zero-extended to DATA_W.
- `CNT_ADDR`, 16'hFFF1: address of the read-only transfer counter.

Ports (one clock; reset is asynchronous and active-high):
- `av_clk`, in, 1: clock, rising edge.
- `av_rst`, in, 1: asynchronous active-high reset.
- `av_read`, in, 1: read request, held by the master until accepted.
- `av_write`, in, 1: write request, held by the master until accepted.
- `av_begin_xfr`, in, 1: one-cycle pulse on the first cycle of each transfer.
- `av_addr`, in, ADDR_W: word address.
- `av_write_data`, in, DATA_W: write data.
- `av_wait_req`, out, 1: stall. The request is accepted in the cycle where req=1 and av_wait_req=0.
- `av_read_data`, out, DATA_W: read data, valid only in a read-accept cycle.

## Operation
Request and counter:
- req = av_read | av_write.
- Wait counter `wcnt`, 4 bits.
- av_wait_req = av_rst | (req & (wcnt != WAIT_CYC)), combinational.

Wait-counter update, each posedge:
- req & av_wait_req: wcnt+1.
- Accept (req & !av_wait_req), or no req: wcnt clears to 0.

Write accept:
- addr < NUM_REGS: reg[addr] <= av_write_data.
- Any other address, including ID_ADDR and CNT_ADDR: ignored.

Read accept, av_read_data (combinational):
- addr < NUM_REGS: reg[addr].
- ID_ADDR: ID_VAL.
- CNT_ADDR: xfr_cnt.
- Any other address: 0.
- Outside a read-accept cycle, av_read_data = 0.

Simultaneous read and write:
- Treated as a write.
- av_read_data = 0.

Transfer counter:
- xfr_cnt, DATA_W bits, increments on every posedge with av_begin_xfr=1, wrapping to 0 past all-ones.
- It is independent of req and wcnt.

Request dropped while stalled:
- wcnt clears to 0.
- No side effect.

Address or data change while stalled:
- Only the values present in the accept cycle are used.

## Timing
Reset:
- While av_rst is high: all registers = 0, wcnt = 0, xfr_cnt = 0, av_wait_req = 1, av_read_data = 0.
- Reset takes effect immediately (asynchronous); release is synchronous to the next av_clk edge.

Access latency:
- WAIT_CYC=N: accept in the (N+1)th cycle of a held request.
- av_wait_req is high for the first N cycles, low in cycle N+1.
- WAIT_CYC=0: av_wait_req never asserts outside reset, and every request is accepted in its first cycle.

Back-to-back requests:
- A request still held in the cycle after an accept is a new transfer with a full N wait cycles.
- Peak throughput is one transfer per N+1 cycles.

Write visibility:
- A written value is visible to a read accepted on any later cycle.

Reset mid-transfer:
- The transfer is aborted; no register update.

## Test plan
- Reset check: av_rst=1, then released -> av_wait_req=1 during reset. After release with no request: av_wait_req=0. Read of addr 0..15 returns 0.
- Write then read (WAIT_CYC=1): write 16'h1234 to addr 3 -> av_wait_req high 1 cycle, accepted in cycle 2. Read addr 3 -> accept in cycle 2 with av_read_data=16'h1234.
- ID and unmapped access: read ID_ADDR -> 16'hA5C3. Read 16'h0100 -> 0. Write 16'hFFFF to ID_ADDR, then re-read -> still 16'hA5C3.
- Transfer counter: 5 transfers, each with an av_begin_xfr pulse -> read CNT_ADDR returns 5, since the read's own pulse is counted only after it.
- Wait-state sweep: WAIT_CYC=0 gives single-cycle accept; WAIT_CYC=3 gives av_wait_req high exactly 3 cycles per access, including two back-to-back reads held continuously.
- Aborts: drop av_read after 1 stall cycle -> no side effects, wcnt restarts. Assert av_rst during a pending write to addr 5 -> reg 5 remains 0.

Source files
------------

// File: rtl/modport_slave.sv
// Avalon-MM slave register bank with ID register, transfer counter
// and a programmable number of wait states per access.
module modport_slave #(
    parameter int          ADDR_W   = 16,
    parameter int          DATA_W   = 16,
    parameter int          NUM_REGS = 16,
    parameter int          WAIT_CYC = 1,
    parameter logic [15:0] ID_ADDR  = 16'hFFF0,
    parameter logic [15:0] ID_VAL   = 16'hA5C3,
    parameter logic [15:0] CNT_ADDR = 16'hFFF1
) (
    input  logic              av_clk,
    input  logic              av_rst,
    input  logic              av_read,
    input  logic              av_write,
    input  logic              av_begin_xfr,
    input  logic [ADDR_W-1:0] av_addr,
    input  logic [DATA_W-1:0] av_write_data,
    output logic              av_wait_req,
    output logic [DATA_W-1:0] av_read_data
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0]        WAIT_V = 4'(WAIT_CYC);
    localparam logic [ADDR_W-1:0] ID_A   = ADDR_W'(ID_ADDR);
    localparam logic [ADDR_W-1:0] CNT_A  = ADDR_W'(CNT_ADDR);
    localparam logic [DATA_W-1:0] ID_V   = DATA_W'(ID_VAL);

    logic [DATA_W-1:0] reg_q [NUM_REGS];
    logic [DATA_W-1:0] reg_d [NUM_REGS];
    logic [3:0]        wcnt_q, wcnt_d;
    logic [DATA_W-1:0] xfr_cnt_q, xfr_cnt_d;

    logic             req;
    logic             accept;
    logic             wr_acc;
    logic             rd_acc;
    logic             in_range;
    logic [IDX_W-1:0] idx;

    assign req         = av_read | av_write;
    assign av_wait_req = av_rst | (req & (wcnt_q != WAIT_V));
    assign accept      = req & ~av_wait_req;
    // A simultaneous read and write is handled purely as a write.
    assign wr_acc      = accept & av_write;
    assign rd_acc      = accept & av_read & ~av_write;
    assign in_range    = 32'(av_addr) < 32'(NUM_REGS);
    assign idx         = av_addr[IDX_W-1:0];

    // Wait counter: counts stall cycles, restarts on accept or idle.
    always_comb begin
        wcnt_d = 4'd0;
        if (req && av_wait_req) begin
            wcnt_d = wcnt_q + 4'd1;
        end
    end

    // Free-running count of transfer-begin pulses.
    always_comb begin
        xfr_cnt_d = xfr_cnt_q;
        if (av_begin_xfr) begin
            xfr_cnt_d = xfr_cnt_q + 1'b1;
        end
    end

    // Register bank update on an accepted in-range write.
    always_comb begin
        reg_d = reg_q;
        if (wr_acc && in_range) begin
            reg_d[idx] = av_write_data;
        end
    end

    // Read mux, driven only during a read-accept cycle.
    always_comb begin
        av_read_data = '0;
        if (rd_acc) begin
            if (in_range) begin
                av_read_data = reg_q[idx];
            end else if (av_addr == ID_A) begin
                av_read_data = ID_V;
            end else if (av_addr == CNT_A) begin
                av_read_data = xfr_cnt_q;
            end
        end
    end

    // State registers, cleared immediately by reset.
    always_ff @(posedge av_clk or posedge av_rst) begin
        if (av_rst) begin
            wcnt_q    <= 4'd0;
            xfr_cnt_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_q[i] <= '0;
            end
        end else begin
            wcnt_q    <= wcnt_d;
            xfr_cnt_q <= xfr_cnt_d;
            reg_q     <= reg_d;
        end
    end

endmodule

// File: tb/tb_modport_slave.sv
// Directed testbench for modport_slave: three instances with
// WAIT_CYC = 1, 0 and 3 share one stimulus bus gated by a selector.
module tb_modport_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic        bx = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    int          sel = 0;

    logic [2:0]  rd_g, wr_g, bx_g;
    logic [2:0]  wreq;
    logic [15:0] rdat0, rdat1, rdat2;

    int cmp_cnt = 0;
    int bad_cnt = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_gate
        assign rd_g[g] = rd & (sel == g);
        assign wr_g[g] = wr & (sel == g);
        assign bx_g[g] = bx & (sel == g);
    end

    modport_slave #(.WAIT_CYC(1)) u_w1 (
        .av_clk(clk), .av_rst(rst),
        .av_read(rd_g[0]), .av_write(wr_g[0]),
        .av_begin_xfr(bx_g[0]), .av_addr(addr),
        .av_write_data(wdata),
        .av_wait_req(wreq[0]), .av_read_data(rdat0)
    );

    modport_slave #(.WAIT_CYC(0)) u_w0 (
        .av_clk(clk), .av_rst(rst),
        .av_read(rd_g[1]), .av_write(wr_g[1]),
        .av_begin_xfr(bx_g[1]), .av_addr(addr),
        .av_write_data(wdata),
        .av_wait_req(wreq[1]), .av_read_data(rdat1)
    );

    modport_slave #(.WAIT_CYC(3)) u_w3 (
        .av_clk(clk), .av_rst(rst),
        .av_read(rd_g[2]), .av_write(wr_g[2]),
        .av_begin_xfr(bx_g[2]), .av_addr(addr),
        .av_write_data(wdata),
        .av_wait_req(wreq[2]), .av_read_data(rdat2)
    );

    function automatic logic [15:0] rdat_of(input int s);
        case (s)
            0:       return rdat0;
            1:       return rdat1;
            default: return rdat2;
        endcase
    endfunction

    // One complete transfer: drives from a negedge, counts stall
    // cycles, captures read data in the accept cycle, then idles.
    task automatic access(input int s, input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] d,
                          output int waits, output logic [15:0] q,
                          output logic ok);
        @(negedge clk);
        sel = s; rd = r; wr = w; addr = a; wdata = d; bx = 1'b1;
        waits = 0; q = '0; ok = 1'b0;
        for (int i = 0; i < 32; i++) begin
            #1;
            if (!wreq[s]) begin
                q = rdat_of(s);
                ok = 1'b1;
                break;
            end
            waits++;
            @(negedge clk);
            bx = 1'b0;
        end
        @(negedge clk);
        rd = 1'b0; wr = 1'b0; bx = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rd = 1'b0; wr = 1'b0; bx = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        cmp_cnt++;
        if (wreq !== 3'b111) begin
            bad_cnt++;
            $display("FAIL reset_wait_req: got %b want 111", wreq);
        end
        cmp_cnt++;
        if (rdat0 !== 16'h0 || rdat1 !== 16'h0 || rdat2 !== 16'h0) begin
            bad_cnt++;
            $display("FAIL reset_rdata: got %h %h %h want 0",
                     rdat0, rdat1, rdat2);
        end
        do_reset();
        @(negedge clk);
        #1;
        cmp_cnt++;
        if (wreq !== 3'b000) begin
            bad_cnt++;
            $display("FAIL idle_wait_req: got %b want 000", wreq);
        end
    endtask

    task automatic test_reset_regs();
        int w; logic [15:0] q; logic ok;
        for (int a = 0; a < 16; a++) begin
            access(1, 1'b1, 1'b0, 16'(a), 16'h0, w, q, ok);
            cmp_cnt++;
            if (!ok || q !== 16'h0) begin
                bad_cnt++;
                $display("FAIL reset_reg%0d: got %h ok=%0d want 0",
                         a, q, ok);
            end
        end
    endtask

    task automatic test_write_read();
        int w; logic [15:0] q; logic ok;
        access(0, 1'b0, 1'b1, 16'd3, 16'h1234, w, q, ok);
        cmp_cnt++;
        if (!ok || w != 1) begin
            bad_cnt++;
            $display("FAIL wr_latency: got %0d waits want 1", w);
        end
        access(0, 1'b1, 1'b0, 16'd3, 16'h0, w, q, ok);
        cmp_cnt++;
        if (!ok || w != 1 || q !== 16'h1234) begin
            bad_cnt++;
            $display("FAIL rd_reg3: got %h waits %0d want 1234 waits 1",
                     q, w);
        end
        access(0, 1'b1, 1'b1, 16'd7, 16'h7777, w, q, ok);
        cmp_cnt++;
        if (!ok || q !== 16'h0) begin
            bad_cnt++;
            $display("FAIL rw_rdata: got %h want 0000", q);
        end
        access(0, 1'b1, 1'b0, 16'd7, 16'h0, w, q, ok);
        cmp_cnt++;
        if (!ok || q !== 16'h7777) begin
            bad_cnt++;
            $display("FAIL rw_as_write: got %h want 7777", q);
        end
    endtask

    task automatic test_id_unmapped();
        int w; logic [15:0] q; logic ok;
        access(0, 1'b1, 1'b0, 16'hFFF0, 16'h0, w, q, ok);
        cmp_cnt++;
        if (!ok || q !== 16'hA5C3) begin
            bad_cnt++;
            $display("FAIL id_read: got %h want a5c3", q);
        end
        access(0, 1'b1, 1'b0, 16'h0100, 16'h0, w, q, ok);
        cmp_cnt++;
        if (!ok || q !== 16'h0) begin
            bad_cnt++;
            $display("FAIL unmapped_read: got %h want 0000", q);
        end
        access(0, 1'b0, 1'b1, 16'hFFF0, 16'hFFFF, w, q, ok);
        access(0, 1'b1, 1'b0, 16'hFFF0, 16'h0, w, q, ok);
        cmp_cnt++;
        if (!ok || q !== 16'hA5C3) begin
            bad_cnt++;
            $display("FAIL id_after_write: got %h want a5c3", q);
        end
        access(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, w, q, ok);
        access(0, 1'b1, 1'b0, 16'h0000, 16'h0, w, q, ok);
        cmp_cnt++;
        if (!ok || q !== 16'h0) begin
            bad_cnt++;
            $display("FAIL no_alias_reg0: got %h want 0000", q);
        end
    endtask

    task automatic test_addr_change();
        int w; logic [15:0] q; logic ok;
        @(negedge clk);
        sel = 0; wr = 1'b1; addr = 16'd9; wdata = 16'h9999; bx = 1'b1;
        @(negedge clk);
        bx = 1'b0; addr = 16'd8; wdata = 16'h8888;
        @(negedge clk);
        wr = 1'b0;
        access(0, 1'b1, 1'b0, 16'd8, 16'h0, w, q, ok);
        cmp_cnt++;
        if (!ok || q !== 16'h8888) begin
            bad_cnt++;
            $display("FAIL late_addr_reg8: got %h want 8888", q);
        end
        access(0, 1'b1, 1'b0, 16'd9, 16'h0, w, q, ok);
        cmp_cnt++;
        if (!ok || q !== 16'h0) begin
            bad_cnt++;
            $display("FAIL early_addr_reg9: got %h want 0000", q);
        end
    endtask

    task automatic test_xfr_counter();
        int w; logic [15:0] q; logic ok;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            access(1, 1'b0, 1'b1, 16'(i), 16'(i + 1), w, q, ok);
        end
        access(1, 1'b1, 1'b0, 16'hFFF1, 16'h0, w, q, ok);
        cmp_cnt++;
        if (!ok || q !== 16'd5) begin
            bad_cnt++;
            $display("FAIL cnt_w0: got %0d want 5", q);
        end
        access(0, 1'b1, 1'b0, 16'hFFF1, 16'h0, w, q, ok);
        cmp_cnt++;
        if (!ok || q !== 16'd1) begin
            bad_cnt++;
            $display("FAIL cnt_w1_own_pulse: got %0d want 1", q);
        end
    endtask

    task automatic test_wait_sweep();
        int w; logic [15:0] q; logic ok;
        access(1, 1'b0, 1'b1, 16'd12, 16'hC0DE, w, q, ok);
        cmp_cnt++;
        if (!ok || w != 0) begin
            bad_cnt++;
            $display("FAIL w0_write_waits: got %0d want 0", w);
        end
        access(1, 1'b1, 1'b0, 16'd12, 16'h0, w, q, ok);
        cmp_cnt++;
        if (!ok || w != 0 || q !== 16'hC0DE) begin
            bad_cnt++;
            $display("FAIL w0_read: got %h waits %0d want c0de waits 0",
                     q, w);
        end
        access(2, 1'b0, 1'b1, 16'd1, 16'h1111, w, q, ok);
        cmp_cnt++;
        if (!ok || w != 3) begin
            bad_cnt++;
            $display("FAIL w3_write_waits: got %0d want 3", w);
        end
        access(2, 1'b0, 1'b1, 16'd2, 16'h2222, w, q, ok);
    endtask

    task automatic test_back_to_back();
        int w1, w2;
        logic [15:0] q1, q2, stall_q;
        w1 = 0; w2 = 0; q1 = '0; q2 = '0; stall_q = '0;
        @(negedge clk);
        sel = 2; rd = 1'b1; addr = 16'd1; bx = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #1;
            if (!wreq[2]) begin
                q1 = rdat2;
                break;
            end
            if (i == 0) stall_q = rdat2;
            w1++;
            @(negedge clk);
            bx = 1'b0;
        end
        @(negedge clk);
        addr = 16'd2; bx = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #1;
            if (!wreq[2]) begin
                q2 = rdat2;
                break;
            end
            w2++;
            @(negedge clk);
            bx = 1'b0;
        end
        @(negedge clk);
        rd = 1'b0; bx = 1'b0;
        cmp_cnt++;
        if (stall_q !== 16'h0) begin
            bad_cnt++;
            $display("FAIL stall_rdata: got %h want 0000", stall_q);
        end
        cmp_cnt++;
        if (w1 != 3 || q1 !== 16'h1111) begin
            bad_cnt++;
            $display("FAIL b2b_first: got %h waits %0d want 1111 waits 3",
                     q1, w1);
        end
        cmp_cnt++;
        if (w2 != 3 || q2 !== 16'h2222) begin
            bad_cnt++;
            $display("FAIL b2b_second: got %h waits %0d want 2222 waits 3",
                     q2, w2);
        end
    endtask

    task automatic test_aborts();
        int w; logic [15:0] q; logic ok;
        @(negedge clk);
        sel = 2; rd = 1'b1; addr = 16'd1; bx = 1'b1;
        @(negedge clk);
        rd = 1'b0; bx = 1'b0;
        access(2, 1'b1, 1'b0, 16'd1, 16'h0, w, q, ok);
        cmp_cnt++;
        if (!ok || w != 3 || q !== 16'h1111) begin
            bad_cnt++;
            $display("FAIL abort_restart: got %h waits %0d want 1111 waits 3",
                     q, w);
        end
        @(negedge clk);
        wr = 1'b1; addr = 16'd6; wdata = 16'h6666; bx = 1'b1;
        @(negedge clk);
        wr = 1'b0; bx = 1'b0;
        access(2, 1'b1, 1'b0, 16'd6, 16'h0, w, q, ok);
        cmp_cnt++;
        if (!ok || q !== 16'h0) begin
            bad_cnt++;
            $display("FAIL dropped_write: got %h want 0000", q);
        end
        @(negedge clk);
        wr = 1'b1; addr = 16'd5; wdata = 16'h5555; bx = 1'b1;
        @(negedge clk);
        bx = 1'b0;
        #2 rst = 1'b1;
        #1;
        cmp_cnt++;
        if (wreq[2] !== 1'b1) begin
            bad_cnt++;
            $display("FAIL async_reset_wait: got %b want 1", wreq[2]);
        end
        @(negedge clk);
        wr = 1'b0;
        rst = 1'b0;
        access(2, 1'b1, 1'b0, 16'd5, 16'h0, w, q, ok);
        cmp_cnt++;
        if (!ok || w != 3 || q !== 16'h0) begin
            bad_cnt++;
            $display("FAIL reset_mid_write: got %h waits %0d want 0 waits 3",
                     q, w);
        end
    endtask

    initial begin
        test_reset();
        test_reset_regs();
        test_write_read();
        test_id_unmapped();
        test_addr_change();
        test_xfr_counter();
        test_wait_sweep();
        test_back_to_back();
        test_aborts();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_cnt, bad_cnt);
        $finish;
    end

endmodule
